// File: rtl/pipe_stage_skid.sv
//==============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline stage register with two-entry skid buffer
//            and synchronous flush that turns held entries into bubbles.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_xfer;
    logic w_out_xfer;

    // Ready depends only on the skid valid bit, so out_ready never reaches it.
    assign in_ready   = !r_skid_valid;
    assign w_in_xfer  = in_valid && !r_skid_valid;
    assign w_out_xfer = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Data registers are left alone; only control must become a bubble.
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (r_skid_valid) begin
            if (w_out_xfer) begin
                r_main_ctrl  <= r_skid_ctrl;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (r_main_valid) begin
            if (w_in_xfer && w_out_xfer) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_in_xfer) begin
                r_skid_ctrl  <= in_ctrl;
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_main_ctrl  <= in_ctrl;
            r_main_data  <= in_data;
            r_main_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It is the next generation of the fixed-width, enable-only inter-stage latch (ID/EX style). It sits between any two CPU pipeline stages. Downstream back-pressure no longer needs a global stall: ready is registered, so no combinational path runs between the two stages. Flush turns in-flight entries into bubbles whose control bits are all zero.

## Interface
- `DATA_W`, default 32: width of the datapath payload (operands, immediates, register IDs packed by the instantiator).
- `CTRL_W`, default 8: width of the control payload (WB/MEM/EX fields); cleared to zero on flush and reset.
- `clk`: input, 1 bit. Clock; all state changes on the posedge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `flush`: input, 1 bit. Synchronous squash of all held entries.
- `in_valid`: input, 1 bit. Upstream presents an entry.
- `in_ready`: output, 1 bit. Stage can accept; a function of registered state only.
- `in_ctrl`: input, CTRL_W bits. Upstream control payload.
- `in_data`: input, DATA_W bits. Upstream data payload.
- `out_valid`: output, 1 bit. Head entry valid.
- `out_ready`: input, 1 bit. Downstream accepts the head this cycle.
- `out_ctrl`: output, CTRL_W bits. Head control payload; 0 whenever `out_valid` = 0.
- `out_data`: output, DATA_W bits. Head data payload.
- `occupancy`: output, 2 bits. Number of held entries (0, 1 or 2).

## Operation
- Storage: main register (drives `out_*`) and skid register, each with a valid bit.
- State is encoded by the valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- `in_ready` = 1 in EMPTY and ONE; 0 in FULL.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Transitions when `rst` = 0 and `flush` = 0:
  - EMPTY, input transfer: main <= in; go to ONE.
  - EMPTY, no input: stay in EMPTY.
  - ONE, input and output transfer: main <= in; stay in ONE.
  - ONE, input transfer only: skid <= in; go to FULL.
  - ONE, output transfer only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, output transfer: main <= skid; go to ONE. Input is not accepted because `in_ready` = 0.
  - FULL, no output transfer: hold.
- Order is strictly FIFO: no entry is dropped, duplicated or reordered without a flush.
- Flush, which has priority over every transfer:
  - Both valid bits clear; main and skid ctrl registers clear to 0.
  - Data registers hold their value (don't-care).
  - Any input offered in the flush cycle is discarded.
  - Any output transfer in the flush cycle still counts as consumed downstream. The downstream stage is flushed by the same hazard unit.
- Reset, which has priority over flush: all valid bits, ctrl and data registers clear to 0.
- `out_ctrl` is gated with main-valid so that a bubble always presents all-zero control.
- `occupancy` = main-valid + skid-valid.

## Timing
- Reset values: `in_ready` = 1 (one cycle after `rst` deasserts, and also during `rst`), `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `occupancy` = 0.
- Latency: 1 cycle. An entry accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 entry per cycle when `out_ready` is held high; FULL is never entered in that case.
- `in_ready` and all `out_*` are register outputs. There is no combinational path from `out_ready` to `in_ready`, and none from `in_*` to `out_*`.
- Back-pressure: when `out_ready` drops, at most one more entry is accepted (into skid). `in_ready` falls the next cycle.
- Recovery: after FULL, `in_ready` returns to 1 one cycle after the first output transfer.
- `out_valid` and `out_*` hold stable while `out_valid` & !`out_ready`.
- Flush at edge N: `out_valid` = 0 and `occupancy` = 0 after edge N. A new entry can be accepted at edge N+1.

## Test plan
- Reset and idle: assert `rst` for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `occupancy` = 0, `in_ready` = 1; no entry is captured.
- Streaming: `out_ready` = 1; send data 0x1..0x8 with ctrl 0xA5 on 8 consecutive cycles → the same sequence appears on `out_data` one cycle later, every cycle, with `occupancy` ≤ 1.
- Back-pressure: with 0x10 held in main, drop `out_ready` and offer 0x11, 0x12 → 0x11 enters skid, `in_ready` = 0, `occupancy` = 2, 0x12 is held upstream. Raise `out_ready` → outputs are 0x10, 0x11, 0x12 in order with no loss.
- Flush while FULL: `occupancy` = 2, assert `flush` with `in_valid` = 1 (0x20) → the next cycle has `out_valid` = 0, `out_ctrl` = 0, `occupancy` = 0; 0x20 never appears on the output.
- Simultaneous transfers in ONE: `in_valid` = `out_ready` = 1 → main is replaced in a single cycle and `occupancy` stays 1.
- Reset mid-operation: `occupancy` = 2, assert `rst` together with `flush` and `in_valid` → all outputs return to reset values; `rst` takes priority.
